// File: rtl/segre_mem_responder.sv
// ---------------------------------------------------------------------------
// segre_mem_responder
//
// Main-memory responder that sits behind the MMU refill/writeback port.
// It accepts one lane-wide read or write at a time. It answers after a fixed
// LATENCY with a single-cycle ready pulse, which carries the lane data and
// the lane-aligned address. The lane array is the backing store for
// simulation and for on-chip synthesis.
//
// Ports
//   clk_i       : clock
//   rst_i       : synchronous active-high reset (array contents are kept)
//   mem_rd_i    : read-lane request, only looked at while idle
//   mem_wr_i    : write-lane request, only looked at while idle (wins over rd)
//   mem_addr_i  : byte address of the request
//   mem_data_i  : write lane data, captured together with the request
//   mem_busy_o  : a request is in flight; new requests are ignored
//   mem_rdy_o   : one-cycle completion pulse
//   mem_data_o  : read data, or the written data echoed back
//   mem_addr_o  : lane-aligned address of the completed request
// ---------------------------------------------------------------------------
module segre_mem_responder #(
  parameter int DCACHE_LANE_SIZE = 128,
  parameter int LANE_SIZE        = DCACHE_LANE_SIZE,
  parameter int MEM_LANES        = 256,
  parameter int LATENCY          = 4,
  parameter int ADDR_SIZE        = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mem_rd_i,
  input  logic                 mem_wr_i,
  input  logic [ADDR_SIZE-1:0] mem_addr_i,
  input  logic [LANE_SIZE-1:0] mem_data_i,
  output logic                 mem_busy_o,
  output logic                 mem_rdy_o,
  output logic [LANE_SIZE-1:0] mem_data_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o
);

  localparam int BYTE_OFF = $clog2(LANE_SIZE / 8);
  localparam int IDX_W    = $clog2(MEM_LANES);
  localparam int CNT_W    = 4;

  // Byte-within-lane bits. They are cleared to form the aligned address.
  localparam logic [ADDR_SIZE-1:0] OFFSET_MASK = ADDR_SIZE'(LANE_SIZE / 8 - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e               state_q,    state_d;
  logic [CNT_W-1:0]     cnt_q,      cnt_d;
  logic                 op_wr_q,    op_wr_d;
  logic [ADDR_SIZE-1:0] req_addr_q, req_addr_d;
  logic [LANE_SIZE-1:0] req_data_q, req_data_d;
  logic [LANE_SIZE-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_SIZE-1:0] rsp_addr_q, rsp_addr_d;

  logic                 access;
  logic                 mem_we;
  logic [IDX_W-1:0]     lane_idx;

  // The lane array is not reset. Contents stay undefined until written.
  logic [LANE_SIZE-1:0] mem_array_q [MEM_LANES];

  // The lane index comes from the latched aligned address. The bits above the
  // index are ignored, so addresses alias modulo the array size.
  assign lane_idx = req_addr_q[BYTE_OFF +: IDX_W];

  // State register and request/response latches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_wr_q    <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
      rsp_data_q <= '0;
      rsp_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_wr_q    <= op_wr_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      rsp_data_q <= rsp_data_d;
      rsp_addr_q <= rsp_addr_d;
    end
  end

  // Next-state logic.
  // IDLE captures a request, and a write wins when both request lines are
  // high. WAIT counts down from LATENCY-1, so WAIT lasts exactly LATENCY
  // cycles. The access happens on the edge that leaves WAIT. Because of this,
  // the data is already registered in the RESP cycle, and a write has
  // committed before any later request can be accepted.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_wr_d    = op_wr_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    access     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_wr_i || mem_rd_i) begin
          op_wr_d    = mem_wr_i;
          req_addr_d = mem_addr_i & ~OFFSET_MASK;
          req_data_d = mem_data_i;
          cnt_d      = CNT_W'(LATENCY - 1);
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Access datapath.
  // The response registers change only on an access. They therefore hold
  // their value from one RESP cycle to the next. A write echoes its own data.
  always_comb begin
    rsp_data_d = rsp_data_q;
    rsp_addr_d = rsp_addr_q;
    mem_we     = 1'b0;
    if (access) begin
      rsp_addr_d = req_addr_q;
      if (op_wr_q) begin
        mem_we     = 1'b1;
        rsp_data_d = req_data_q;
      end else begin
        rsp_data_d = mem_array_q[lane_idx];
      end
    end
  end

  // Array write port.
  // It is gated by reset, so a write that is still pending when reset
  // arrives is dropped and the array is left unchanged.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) begin
      mem_array_q[lane_idx] <= req_data_q;
    end
  end

  // Output logic.
  // busy and ready depend only on the registered state, never on the request
  // inputs.
  always_comb begin
    mem_busy_o = (state_q != ST_IDLE);
    mem_rdy_o  = (state_q == ST_RESP);
  end

  assign mem_data_o = rsp_data_q;
  assign mem_addr_o = rsp_addr_q;

endmodule

// File: tb/tb_segre_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_segre_mem_responder
//
// Two responders: dut0 with LATENCY=4 and dut1 with LATENCY=1. Stimulus
// tasks update a behavioural lane memory and push the expected response
// into a scoreboard queue. One monitor per DUT compares busy/ready against
// the request timeline, pops an entry on every ready pulse, and checks the
// held data/address outputs on every cycle.
// ---------------------------------------------------------------------------
module tb_segre_mem_responder;

  localparam int LANE  = 128;
  localparam int AW    = 32;
  localparam int LANES = 256;

  typedef struct {
    int              id;
    logic [LANE-1:0] data;
    logic [AW-1:0]   addr;
    bit              known;
    bit              isWr;
    int              idx;
    logic [LANE-1:0] prevData;
    bit              prevKnown;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic            rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
  logic [AW-1:0]   addr0 = '0, addr1 = '0;
  logic [LANE-1:0] wdata0 = '0, wdata1 = '0;
  logic            busy0, rdy0, busy1, rdy1;
  logic [LANE-1:0] rdata0, rdata1;
  logic [AW-1:0]   raddr0, raddr1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   monOn = 1'b0;

  exp_t            expQ[$];
  int              lastT[2];
  bit              lastValid[2];
  logic [LANE-1:0] heldData[2];
  logic [AW-1:0]   heldAddr[2];
  bit              heldKnown[2];
  logic [LANE-1:0] refMem[2][LANES];
  bit              refKnown[2][LANES];

  segre_mem_responder #(.LANE_SIZE(LANE), .MEM_LANES(LANES), .LATENCY(4), .ADDR_SIZE(AW)) dut0 (
    .clk_i(clk), .rst_i(rst), .mem_rd_i(rd0), .mem_wr_i(wr0), .mem_addr_i(addr0),
    .mem_data_i(wdata0), .mem_busy_o(busy0), .mem_rdy_o(rdy0), .mem_data_o(rdata0),
    .mem_addr_o(raddr0)
  );

  segre_mem_responder #(.LANE_SIZE(LANE), .MEM_LANES(LANES), .LATENCY(1), .ADDR_SIZE(AW)) dut1 (
    .clk_i(clk), .rst_i(rst), .mem_rd_i(rd1), .mem_wr_i(wr1), .mem_addr_i(addr1),
    .mem_data_i(wdata1), .mem_busy_o(busy1), .mem_rdy_o(rdy1), .mem_data_o(rdata1),
    .mem_addr_o(raddr1)
  );

  // Free-running clock and a cycle counter that advances on every rising edge.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int latOf(input int id);
    return (id == 0) ? 4 : 1;
  endfunction

  // Stimulus is driven 1 time unit after the rising edge. Sampling happens on
  // the falling edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic driveInputs(input int id, input bit wr, input bit rd,
                             input logic [AW-1:0] addr, input logic [LANE-1:0] data);
    if (id == 0) begin
      wr0 = wr; rd0 = rd; addr0 = addr; wdata0 = data;
    end else begin
      wr1 = wr; rd1 = rd; addr1 = addr; wdata1 = data;
    end
  endtask

  // Issue a request as soon as the reference timeline says the responder is
  // idle again, which is LATENCY+2 cycles after the previous acceptance.
  // The expected response is recorded at issue time.
  task automatic applyStimulus(input int id, input bit wr, input bit rd,
                               input logic [AW-1:0] addr, input logic [LANE-1:0] data);
    int   guard;
    int   lat;
    exp_t e;
    guard = 0;
    lat   = latOf(id);
    while (lastValid[id] && cyc < lastT[id] + lat + 2) begin
      nextCycle();
      guard++;
      if (guard > 200) begin
        errors++;
        $display("[TB] FAIL idle-wait dut%0d: still waiting after %0d cycles, required <= 200", id, guard);
        break;
      end
    end
    driveInputs(id, wr, rd, addr, data);
    e.id        = id;
    e.idx       = int'(addr[4 +: 8]);
    e.addr      = addr & ~32'hF;
    e.isWr      = wr;
    e.prevData  = refMem[id][e.idx];
    e.prevKnown = refKnown[id][e.idx];
    if (wr) begin
      refMem[id][e.idx]   = data;
      refKnown[id][e.idx] = 1'b1;
      e.data  = data;
      e.known = 1'b1;
    end else begin
      e.data  = refMem[id][e.idx];
      e.known = refKnown[id][e.idx];
    end
    expQ.push_back(e);
    lastT[id]     = cyc;
    lastValid[id] = 1'b1;
    nextCycle();
    driveInputs(id, 1'b0, 1'b0, '0, '0);
  endtask

  // Drive a one-cycle request that must be ignored because a request is
  // already in flight. Nothing is recorded.
  task automatic pulseIgnored(input int id, input bit wr, input bit rd,
                              input logic [AW-1:0] addr, input logic [LANE-1:0] data);
    driveInputs(id, wr, rd, addr, data);
    nextCycle();
    driveInputs(id, 1'b0, 1'b0, '0, '0);
  endtask

  // Assert reset for one edge. Pending writes never commit, so their model
  // updates are undone, and both responders return to all-zero outputs.
  task automatic resetPulse();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    for (int k = expQ.size() - 1; k >= 0; k--) begin
      if (expQ[k].isWr) begin
        refMem[expQ[k].id][expQ[k].idx]   = expQ[k].prevData;
        refKnown[expQ[k].id][expQ[k].idx] = expQ[k].prevKnown;
      end
    end
    expQ.delete();
    for (int id = 0; id < 2; id++) begin
      lastValid[id] = 1'b0;
      heldData[id]  = '0;
      heldAddr[id]  = '0;
      heldKnown[id] = 1'b1;
    end
  endtask

  // Compare one DUT's outputs against the reference timeline and the
  // scoreboard.
  task automatic checkOutput(input int id, input logic busy, input logic rdy,
                             input logic [LANE-1:0] data, input logic [AW-1:0] addr);
    int lat;
    bit expBusy;
    bit expRdy;
    int hit;
    lat     = latOf(id);
    expBusy = lastValid[id] && (cyc >= lastT[id] + 1) && (cyc <= lastT[id] + lat + 1);
    expRdy  = lastValid[id] && (cyc == lastT[id] + lat + 1);
    checks++;
    if (busy !== expBusy) begin
      errors++;
      $display("[TB] FAIL busy dut%0d cyc %0d: got %b required %b", id, cyc, busy, expBusy);
    end
    checks++;
    if (rdy !== expRdy) begin
      errors++;
      $display("[TB] FAIL ready dut%0d cyc %0d: got %b required %b", id, cyc, rdy, expRdy);
    end
    if (rdy === 1'b1) begin
      hit = -1;
      foreach (expQ[k]) if (hit < 0 && expQ[k].id == id) hit = k;
      if (hit < 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard dut%0d cyc %0d: ready pulse with no expected response", id, cyc);
      end else begin
        heldData[id]  = expQ[hit].data;
        heldAddr[id]  = expQ[hit].addr;
        heldKnown[id] = expQ[hit].known;
        expQ.delete(hit);
      end
    end
    if (heldKnown[id]) begin
      checks++;
      if (data !== heldData[id]) begin
        errors++;
        $display("[TB] FAIL data dut%0d cyc %0d: got %h required %h", id, cyc, data, heldData[id]);
      end
    end
    checks++;
    if (addr !== heldAddr[id]) begin
      errors++;
      $display("[TB] FAIL addr dut%0d cyc %0d: got %h required %h", id, cyc, addr, heldAddr[id]);
    end
  endtask

  // Monitors sample both DUTs on the falling edge, away from the active edge.
  always @(negedge clk) if (monOn) checkOutput(0, busy0, rdy0, rdata0, raddr0);
  always @(negedge clk) if (monOn) checkOutput(1, busy1, rdy1, rdata1, raddr1);

  // Test sequence: prewrite, directed cases, random traffic, then
  // LATENCY=1 back-to-back on dut1.
  initial begin : stimulus
    logic [LANE-1:0] dA;
    logic [LANE-1:0] dE;
    logic [LANE-1:0] dF;
    logic [AW-1:0]   ra;
    int              op;
    int              lane;

    for (int id = 0; id < 2; id++) begin
      lastValid[id] = 1'b0;
      lastT[id]     = 0;
      heldData[id]  = '0;
      heldAddr[id]  = '0;
      heldKnown[id] = 1'b1;
      for (int l = 0; l < LANES; l++) begin
        refKnown[id][l] = 1'b0;
        refMem[id][l]   = '0;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    monOn = 1'b1;
    nextCycle();

    // Give lanes 0..63 of dut0 known contents.
    for (int l = 0; l < 64; l++)
      applyStimulus(0, 1'b1, 1'b0, 32'(l) << 4, {$urandom, $urandom, $urandom, $urandom});

    // Write then read back through an unaligned address in the same lane.
    dA = 128'h0123456789ABCDEF0123456789ABCDEF;
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0040, dA);
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_004C, '0);

    // A write pulsed in cycle T+2 of an in-flight read must be ignored.
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0100, '0);
    nextCycle();
    pulseIgnored(0, 1'b1, 1'b0, 32'h0000_0200, {4{32'hDEAD_BEEF}});
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0200, '0);

    // Aliasing: 0x1000 maps to lane 0.
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_1000, {16{8'hAA}});
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0000, '0);

    // Both request lines high: the write wins.
    applyStimulus(0, 1'b1, 1'b1, 32'h0000_0080, {4{32'h5A5A_C3C3}});
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0080, '0);

    // Reset in cycle T+2 of a write: no ready pulse, and the lane keeps F.
    dF = {4{32'hF0F0_1234}};
    dE = {4{32'hEEEE_5678}};
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0300, dF);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0300, dE);
    nextCycle();
    resetPulse();
    nextCycle();
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0300, '0);

    // Random traffic over lanes 0..63, with aliased upper bits and random
    // byte offsets.
    for (int i = 0; i < 80; i++) begin
      op   = int'($urandom_range(0, 5));
      lane = int'($urandom_range(0, 63));
      ra   = ($urandom & 32'hFFFF_F00F) | (32'(lane) << 4);
      if (op <= 1)      applyStimulus(0, 1'b1, 1'b0, ra, {$urandom, $urandom, $urandom, $urandom});
      else if (op <= 4) applyStimulus(0, 1'b0, 1'b1, ra, '0);
      else              applyStimulus(0, 1'b1, 1'b1, ra, {$urandom, $urandom, $urandom, $urandom});
      if ($urandom_range(0, 3) == 0)
        pulseIgnored(0, 1'b1, 1'b0, ($urandom & 32'hFFFF_F00F) | (32'($urandom_range(0, 63)) << 4),
                     {$urandom, $urandom, $urandom, $urandom});
      repeat ($urandom_range(0, 3)) nextCycle();
    end

    // LATENCY=1: two reads issued as soon as busy clears.
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0010, {4{32'h1111_0001}});
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0020, {4{32'h2222_0002}});
    applyStimulus(1, 1'b0, 1'b1, 32'h0000_0010, '0);
    applyStimulus(1, 1'b0, 1'b1, 32'h0000_0020, '0);

    repeat (12) nextCycle();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d responses outstanding, required 0", expQ.size());
    end
    monOn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
